icache_sram_assoc: RTL and testbench

Parametrised N-way set-associative instruction-cache storage array with tag compare, valid bits, tree pseudo-LRU replacement and a set-by-set invalidation sweeper. It is the successor to the fixed two-way I-cache SRAM. It sits between the I-cache controller, which issues lookups and refills, and the fetch datapath, which consumes `dataOut`. Lookups are registered: one cycle from request to result.

---
 rtl/icache_sram_assoc.sv | 169 ++++++++++++++++
 tb/tb_icache_sram_assoc.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_sram_assoc.sv
// N-way set-associative I-cache storage: tag compare, valid bits, tree pseudo-LRU
// replacement and a set-by-set invalidation sweep after reset or flush.
module icache_sram_assoc #(
    parameter int TAG_W      = 22,
    parameter int SET_W      = 4,
    parameter int WAYS       = 4,
    parameter int BLOCK_BITS = 128
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic                                     memWen,
    input  logic [TAG_W+SET_W-1:0]                   blockAddr,
    input  logic [BLOCK_BITS-1:0]                    dataIn,
    input  logic                                     flush,
    output logic                                     ready,
    output logic                                     rdValid,
    output logic                                     hit,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] hitWay,
    output logic [BLOCK_BITS-1:0]                    dataOut
);
    localparam int SETS   = 1 << SET_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t state;
    logic [SET_W-1:0] counter;

    logic [TAG_W-1:0]      tagMem   [SETS][WAYS];
    logic [BLOCK_BITS-1:0] dataMem  [SETS][WAYS];
    logic [WAYS-1:0]       validMem [SETS];
    logic [PLRU_W-1:0]     plruMem  [SETS];

    logic [TAG_W-1:0] reqTag;
    logic [SET_W-1:0] reqSet;
    logic             accept;
    logic             hitAny;
    logic             freeAny;
    logic [WAY_W-1:0] hitIdx;
    logic [WAY_W-1:0] freeIdx;
    logic [WAY_W-1:0] victimIdx;
    logic [WAY_W-1:0] fillWay;
    logic [WAY_W-1:0] touchWay;
    logic [PLRU_W-1:0] newPlru;

    assign reqTag = blockAddr[SET_W +: TAG_W];
    assign reqSet = blockAddr[SET_W-1:0];
    assign accept = en && ready && !flush;

    // Tag match, first free way, PLRU victim walk and the PLRU value after touching the used way.
    // Heap order means nodes on any root-to-leaf path are visited in increasing index order,
    // so a single pass over all nodes follows the path.
    always_comb begin : lookupLogic
        int lo;
        int span;
        int cur;
        hitAny  = 1'b0;
        hitIdx  = '0;
        freeAny = 1'b0;
        freeIdx = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validMem[reqSet][w] && tagMem[reqSet][w] == reqTag && !hitAny) begin
                hitAny = 1'b1;
                hitIdx = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validMem[reqSet][w]) begin
                freeAny = 1'b1;
                freeIdx = WAY_W'(w);
            end
        end
        lo   = 0;
        span = WAYS;
        cur  = 0;
        for (int n = 0; n < WAYS - 1; n++) begin
            if (n == cur) begin
                if (plruMem[reqSet][n]) begin
                    lo  = lo + span / 2;
                    cur = 2 * n + 2;
                end else begin
                    cur = 2 * n + 1;
                end
                span = span / 2;
            end
        end
        victimIdx = WAY_W'(lo);
        fillWay   = hitAny ? hitIdx : (freeAny ? freeIdx : victimIdx);
        touchWay  = memWen ? fillWay : hitIdx;
        newPlru   = plruMem[reqSet];
        lo   = 0;
        span = WAYS;
        cur  = 0;
        for (int n = 0; n < WAYS - 1; n++) begin
            if (n == cur) begin
                if (int'(touchWay) < lo + span / 2) begin
                    newPlru[n] = 1'b1;
                    cur        = 2 * n + 1;
                end else begin
                    newPlru[n] = 1'b0;
                    lo         = lo + span / 2;
                    cur        = 2 * n + 2;
                end
                span = span / 2;
            end
        end
    end

    // Storage arrays carry no reset; the sweep invalidates every set before requests are taken.
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            validMem[counter] <= '0;
            plruMem[counter]  <= '0;
        end else if (accept) begin
            if (memWen) begin
                tagMem[reqSet][fillWay]   <= reqTag;
                dataMem[reqSet][fillWay]  <= dataIn;
                validMem[reqSet][fillWay] <= 1'b1;
                plruMem[reqSet]           <= newPlru;
            end else if (hitAny) begin
                plruMem[reqSet] <= newPlru;
            end
        end
    end

    // Sweep/idle control and registered lookup results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SWEEP;
            counter <= '0;
            ready   <= 1'b0;
            rdValid <= 1'b0;
            hit     <= 1'b0;
            hitWay  <= '0;
            dataOut <= '0;
        end else begin
            rdValid <= 1'b0;
            if (flush) begin
                state   <= SWEEP;
                counter <= '0;
                ready   <= 1'b0;
                hit     <= 1'b0;
                hitWay  <= '0;
                dataOut <= '0;
            end else begin
                case (state)
                    SWEEP: begin
                        counter <= counter + 1'b1;
                        if (counter == SET_W'(SETS - 1)) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end
                    end
                    IDLE: begin
                        if (accept && !memWen) begin
                            rdValid <= 1'b1;
                            hit     <= hitAny;
                            hitWay  <= hitAny ? hitIdx : '0;
                            dataOut <= hitAny ? dataMem[reqSet][hitIdx] : '0;
                        end
                    end
                    default: state <= SWEEP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_icache_sram_assoc.sv
// Self-checking bench for icache_sram_assoc: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural cache model.
module tb_icache_sram_assoc;
    localparam int TAG_W = 22;
    localparam int SET_W = 4;
    localparam int WAYS  = 4;
    localparam int BB    = 128;
    localparam int SETS  = 16;
    localparam int LOG   = 2;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic memWen;
    logic [TAG_W+SET_W-1:0] blockAddr;
    logic [BB-1:0] dataIn;
    logic flush;
    logic ready;
    logic rdValid;
    logic hit;
    logic [1:0] hitWay;
    logic [BB-1:0] dataOut;

    int testsRun = 0;
    int testsFailed = 0;

    icache_sram_assoc #(.TAG_W(TAG_W), .SET_W(SET_W), .WAYS(WAYS), .BLOCK_BITS(BB)) dut (
        .clk(clk), .rst(rst), .en(en), .memWen(memWen), .blockAddr(blockAddr),
        .dataIn(dataIn), .flush(flush), .ready(ready), .rdValid(rdValid),
        .hit(hit), .hitWay(hitWay), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-set line table plus tree bits, all state lost on reset/flush.
    logic [TAG_W-1:0] mTag   [SETS][WAYS];
    logic [BB-1:0]    mData  [SETS][WAYS];
    logic             mValid [SETS][WAYS];
    logic [WAYS-2:0]  mPlru  [SETS];
    int sweepLeft = 0;
    logic expReady = 1'b0;
    logic expRdValid = 1'b0;
    logic expHit = 1'b0;
    logic [1:0] expWay = '0;
    logic [BB-1:0] expData = '0;

    function automatic void modelClear();
        for (int s = 0; s < SETS; s++) begin
            mPlru[s] = '0;
            for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
        end
    endfunction

    function automatic int findTag(int s, logic [TAG_W-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (mValid[s][w] && mTag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int victimOf(int s);
        int node = 0;
        int way = 0;
        for (int l = 0; l < LOG; l++) begin
            int b = int'(mPlru[s][node]);
            way = way * 2 + b;
            node = 2 * node + 1 + b;
        end
        return way;
    endfunction

    function automatic void touch(int s, int w);
        int node = 0;
        for (int l = 0; l < LOG; l++) begin
            int b = (w >> (LOG - 1 - l)) & 1;
            mPlru[s][node] = (b == 0);
            node = 2 * node + 1 + b;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelClear();
            sweepLeft = SETS;
            expReady = 1'b0;
            expRdValid = 1'b0;
            expHit = 1'b0;
            expWay = '0;
            expData = '0;
        end else begin
            int s;
            int w;
            logic [TAG_W-1:0] t;
            s = int'(blockAddr[SET_W-1:0]);
            t = blockAddr[SET_W +: TAG_W];
            expRdValid = 1'b0;
            if (flush) begin
                modelClear();
                sweepLeft = SETS;
                expReady = 1'b0;
                expHit = 1'b0;
                expWay = '0;
                expData = '0;
            end else if (sweepLeft > 0) begin
                sweepLeft = sweepLeft - 1;
                expReady = (sweepLeft == 0);
            end else if (en) begin
                w = findTag(s, t);
                if (memWen) begin
                    if (w < 0) begin
                        for (int k = WAYS - 1; k >= 0; k--)
                            if (!mValid[s][k]) w = k;
                    end
                    if (w < 0) w = victimOf(s);
                    mTag[s][w] = t;
                    mData[s][w] = dataIn;
                    mValid[s][w] = 1'b1;
                    touch(s, w);
                end else begin
                    expRdValid = 1'b1;
                    if (w >= 0) begin
                        expHit = 1'b1;
                        expWay = 2'(w);
                        expData = mData[s][w];
                        touch(s, w);
                    end else begin
                        expHit = 1'b0;
                        expWay = '0;
                        expData = '0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("ready", BB'(ready), BB'(expReady));
        chk("rdValid", BB'(rdValid), BB'(expRdValid));
        chk("hit", BB'(hit), BB'(expHit));
        chk("hitWay", BB'(hitWay), BB'(expWay));
        chk("dataOut", dataOut, expData);
    end

    task automatic applyStimulus(input logic e, input logic w, input logic [TAG_W-1:0] t,
                                 input logic [SET_W-1:0] s, input logic [BB-1:0] d, input logic f);
        en = e;
        memWen = w;
        blockAddr = {t, s};
        dataIn = d;
        flush = f;
        @(posedge clk);
        #2;
        en = 1'b0;
        memWen = 1'b0;
        flush = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic rv, input logic h,
                               input logic [1:0] way, input logic [BB-1:0] d);
        chk({name, ".rdValid"}, BB'(rdValid), BB'(rv));
        chk({name, ".hit"}, BB'(hit), BB'(h));
        chk({name, ".hitWay"}, BB'(hitWay), BB'(way));
        chk({name, ".dataOut"}, dataOut, d);
    endtask

    task automatic fill(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s, input logic [BB-1:0] d);
        applyStimulus(1'b1, 1'b1, t, s, d, 1'b0);
    endtask

    task automatic lookup(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s);
        applyStimulus(1'b1, 1'b0, t, s, '0, 1'b0);
    endtask

    task automatic expectReadyLow(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk(name, BB'(ready), BB'(1'b0));
            @(posedge clk);
            #2;
        end
        chk({name, ".rise"}, BB'(ready), BB'(1'b1));
    endtask

    localparam logic [TAG_W-1:0] ONES = '1;
    localparam logic [BB-1:0] ALL1 = '1;
    localparam logic [BB-1:0] REFILL = {32'hFFFFFFFF, 96'h0};

    initial begin
        rst = 1'b1;
        en = 1'b0;
        memWen = 1'b0;
        blockAddr = '0;
        dataIn = '0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        expectReadyLow("resetSweep", SETS);

        // Set 0: two fills, refill of an existing tag, then two more distinct tags.
        fill('0, 4'd0, '0);
        fill(ONES, 4'd0, ALL1);
        lookup(ONES, 4'd0);
        checkOutput("set0Ones", 1'b1, 1'b1, 2'd1, ALL1);
        fill(ONES, 4'd0, REFILL);
        lookup(ONES, 4'd0);
        checkOutput("set0Refill", 1'b1, 1'b1, 2'd1, REFILL);
        fill(22'd5, 4'd0, 128'h5555);
        fill(22'd6, 4'd0, 128'h6666);
        lookup('0, 4'd0);
        checkOutput("set0Tag0", 1'b1, 1'b1, 2'd0, '0);
        lookup(22'd5, 4'd0);
        checkOutput("set0Tag5", 1'b1, 1'b1, 2'd2, 128'h5555);
        lookup(22'd6, 4'd0);
        checkOutput("set0Tag6", 1'b1, 1'b1, 2'd3, 128'h6666);

        // Set 2: PLRU victim after touching way 0 must be way 2.
        fill(22'h100, 4'd2, 128'hA);
        fill(22'h101, 4'd2, 128'hB);
        fill(22'h102, 4'd2, 128'hC);
        fill(22'h103, 4'd2, 128'hD);
        lookup(22'h100, 4'd2);
        checkOutput("set2A", 1'b1, 1'b1, 2'd0, 128'hA);
        fill(22'h104, 4'd2, 128'hE);
        lookup(22'h102, 4'd2);
        checkOutput("set2CEvicted", 1'b1, 1'b0, 2'd0, '0);
        lookup(22'h100, 4'd2);
        checkOutput("set2A2", 1'b1, 1'b1, 2'd0, 128'hA);
        lookup(22'h101, 4'd2);
        checkOutput("set2B", 1'b1, 1'b1, 2'd1, 128'hB);
        lookup(22'h103, 4'd2);
        checkOutput("set2D", 1'b1, 1'b1, 2'd3, 128'hD);
        lookup(22'h104, 4'd2);
        checkOutput("set2E", 1'b1, 1'b1, 2'd2, 128'hE);

        // Flush together with a lookup: request dropped, everything invalidated.
        applyStimulus(1'b1, 1'b0, 22'h100, 4'd2, '0, 1'b1);
        checkOutput("flushDrop", 1'b0, 1'b0, 2'd0, '0);
        expectReadyLow("flushSweep", SETS);
        lookup(22'h100, 4'd2);
        checkOutput("afterFlushA", 1'b1, 1'b0, 2'd0, '0);
        lookup(ONES, 4'd0);
        checkOutput("afterFlushOnes", 1'b1, 1'b0, 2'd0, '0);

        // Reset in the middle of a sweep, with lookups ignored while not ready.
        fill(22'h42, 4'd3, 128'h42);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            chk("rstSweep.ready", BB'(ready), BB'(1'b0));
            chk("rstSweep.rdValid", BB'(rdValid), BB'(1'b0));
            en = 1'b1;
            memWen = 1'b0;
            blockAddr = {22'h42, 4'd3};
            @(posedge clk);
            #2;
        end
        en = 1'b0;
        chk("rstSweep.rise", BB'(ready), BB'(1'b1));
        chk("rstSweep.noResp", BB'(rdValid), BB'(1'b0));

        // Randomized traffic on a few sets with a small tag pool to force evictions.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            memWen = ($urandom_range(0, 2) == 0);
            blockAddr = {22'(22'h200 + $urandom_range(0, 5)), 4'($urandom_range(0, 3))};
            dataIn = {$urandom, $urandom, $urandom, $urandom};
            flush = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #2;
        end
        en = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #2;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
